// File: rtl/i2c_bit_ctrl.sv
// I2C master bit-level controller: START/WRITE/READ/STOP sequencing, one phase per iTick, 4 ticks per SCL bit.
// Latency: START/STOP 4 ticks, WRITE/READ 36 ticks, NOP 1 clk; I2C_CLK_STRETCH_EN lets a low SCL stall phases 2/3.
module i2c_bit_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       iTick,
    input  logic [2:0] iCmd,
    input  logic       iCmdValid,
    input  logic [7:0] iData,
    input  logic       iAck,
    input  logic       iSda,
    input  logic       iScl,
    output logic       oReady,
    output logic       oDone,
    output logic [7:0] oData,
    output logic       oAckIn,
    output logic       oSclOe,
    output logic       oSdaOe
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP} state_t;

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic       ack_q, ack_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic [7:0] data_q, data_d;
    logic       ack_in_q, ack_in_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       advance;
    logic       load_drv;
    logic [1:0] drv;

    // {scl_oe, sda_oe} for a given state/phase; bit index 8 is the ack slot.
    function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph, logic [3:0] bi,
                                              logic [7:0] tx, logic ack);
        logic       bitv;
        logic [1:0] r;
        bitv = 1'b1;
        r    = 2'b00;
        case (st)
            S_START: r = (ph == 2'd0) ? 2'b00 : (ph == 2'd1) ? 2'b01 : 2'b11;
            S_STOP:  r = (ph == 2'd0) ? 2'b11 : (ph == 2'd1) ? 2'b01 : 2'b00;
            S_WRITE, S_READ: begin
                if (bi[3])               bitv = (st == S_READ) ? ack : 1'b1;
                else if (st == S_WRITE)  bitv = tx[3'd7 - bi[2:0]];
                r = {~ph[1], ~bitv};
            end
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        ack_d    = ack_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        data_d   = data_q;
        ack_in_d = ack_in_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        load_drv = 1'b0;
        drv      = 2'b00;
        advance  = iTick;
`ifdef I2C_CLK_STRETCH_EN
        if (phase_q[1] && !iScl) advance = 1'b0;
`endif

        if (state_q == S_IDLE) begin
            if (iCmdValid && ready_q) begin
                case (iCmd)
                    CMD_START: state_d = S_START;
                    CMD_WRITE: begin state_d = S_WRITE; tx_d = iData; end
                    CMD_READ:  begin state_d = S_READ;  ack_d = iAck; end
                    CMD_STOP:  state_d = S_STOP;
                    default:   done_d = 1'b1;
                endcase
                if (state_d != S_IDLE) begin
                    ready_d  = 1'b0;
                    phase_d  = 2'd0;
                    bit_d    = 4'd0;
                    load_drv = 1'b1;
                    drv      = line_drive(state_d, 2'd0, 4'd0, iData, iAck);
                end
            end
        end else if (advance) begin
            // SDA is sampled on the tick that ends phase 2 (SCL high).
            if (phase_q == 2'd2) begin
                if (state_q == S_WRITE && bit_q[3]) ack_in_d = iSda;
                if (state_q == S_READ && !bit_q[3]) data_d = {data_q[6:0], iSda};
            end
            if (phase_q != 2'd3) begin
                phase_d  = phase_q + 2'd1;
                load_drv = 1'b1;
                drv      = line_drive(state_q, phase_d, bit_q, tx_q, ack_q);
            end else if (state_q == S_START || state_q == S_STOP || bit_q[3]) begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
                phase_d = 2'd0;
                bit_d   = 4'd0;
                if (state_q != S_STOP) scl_oe_d = 1'b1;
            end else begin
                phase_d  = 2'd0;
                bit_d    = bit_q + 4'd1;
                load_drv = 1'b1;
                drv      = line_drive(state_q, 2'd0, bit_d, tx_q, ack_q);
            end
        end

        if (load_drv) begin
            scl_oe_d = drv[1];
            sda_oe_d = drv[0];
        end
    end

`ifndef I2C_CLK_STRETCH_EN
    logic unused_scl;
    assign unused_scl = iScl;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            bit_q    <= 4'd0;
            tx_q     <= 8'h00;
            ack_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            data_q   <= 8'h00;
            ack_in_q <= 1'b1;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            ack_q    <= ack_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            data_q   <= data_d;
            ack_in_q <= ack_in_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign oReady = ready_q;
    assign oDone  = done_q;
    assign oData  = data_q;
    assign oAckIn = ack_in_q;
    assign oSclOe = scl_oe_q;
    assign oSdaOe = sda_oe_q;
endmodule

// File: doc/i2c_bit_ctrl.md
I2C_BIT_CTRL -- requirements
Module: i2c_bit_ctrl

Interface
REQ-001 Parameter: none; bus rate is set solely by the iTick rate (SCL frequency = iTick rate / 4).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iTick  input  1  one-clk-wide phase strobe from the tick generator; one tick = one quarter SCL period.
REQ-005 iCmd  input  3  command: 0 NOP, 1 START, 2 WRITE, 3 READ, 4 STOP; other codes = NOP.
REQ-006 iCmdValid  input  1  command strobe; accepted only when oReady=1.
REQ-007 iData  input  8  byte for WRITE, MSB first.
REQ-008 iAck  input  1  ack bit driven by master after READ (0=ACK, 1=NACK).
REQ-009 iSda / iScl  input  1 each  sampled bus line levels.
REQ-010 oReady  output  1  idle, can accept a command.
REQ-011 oDone  output  1  one-clk pulse when a command completes.
REQ-012 oData  output  8  byte captured by READ.
REQ-013 oAckIn  output  1  ack bit sampled from slave after WRITE.
REQ-014 oSclOe / oSdaOe  output  1 each  1 = pull line low, 0 = release (open-drain).

Function
REQ-015 States: IDLE, START, WRITE, READ, STOP; phase counter 0..3 advances only on clocks where iTick=1.
REQ-016 Command accepted on the clock where iCmdValid=1 and oReady=1; iData and iAck latched then; oReady falls next clock.
REQ-017 iCmdValid while oReady=0 is ignored without side effect.
REQ-018 START: phase0 SDA released, SCL released; phase1 SDA low; phase2 SCL low; phase3 hold; done after 4 ticks.
REQ-019 Each data bit: phase0 SCL low, SDA set to bit; phase1 SCL low; phase2 SCL released; SDA sampled at end of phase2 (tick on which phase2->3); phase3 SCL released; then SCL low at next phase0.
REQ-020 WRITE: 8 data bits MSB first then 9th bit with SDA released; oAckIn = sampled 9th bit; 36 ticks total.
REQ-021 READ: 8 bits with SDA released, shifted into oData MSB first; 9th bit drives latched iAck; 36 ticks total.
REQ-022 STOP: phase0 SCL low, SDA low; phase1 SCL released; phase2 SDA released; phase3 hold; 4 ticks.
REQ-023 oDone pulses on the clock the final tick of a command is consumed; oReady=1 the same clock; next command may be accepted that clock.
REQ-024 No iTick: all outputs hold; no timeout.
REQ-025 Bit counter wraps 8->0 only at command end; oData stable from oDone until next READ's first sample.
REQ-026 NOP/undefined codes accepted and complete with oDone one clock later, bus untouched.
REQ-027 After STOP, both lines released; after START/WRITE/READ, SCL held low.

Reset
REQ-028 reset=1 immediately forces IDLE, phase=0, bit counter=0, oReady=1, oDone=0, oData=0x00, oAckIn=1, oSclOe=0, oSdaOe=0.
REQ-029 Reset mid-command aborts it without oDone; lines released asynchronously.

Configuration
REQ-030 Macro I2C_CLK_STRETCH_EN defined: in phase2/3, if iScl=0 the phase counter does not advance on iTick (slave stretching) until iScl=1.
REQ-031 Macro undefined: iScl ignored; timing purely tick-driven.

Verification
REQ-032 reset mid-WRITE at tick 10 -> oSclOe=0, oSdaOe=0, oReady=1 same cycle, no oDone.
REQ-033 START then WRITE iData=0xA5 with iSda=0 at bit 9 -> SDA pattern 1,0,1,0,0,1,0,1 on SCL high, oAckIn=0, oDone after 36 ticks.
REQ-034 READ with iAck=1, slave drives 0x3C -> oData=0x3C, SDA released on bit 9, oDone after 36 ticks.
REQ-035 STOP -> SDA rises while SCL released, then both lines released, oReady=1.
REQ-036 iCmdValid pulsed during WRITE with iCmd=STOP -> ignored, WRITE completes unchanged.
REQ-037 With I2C_CLK_STRETCH_EN, iScl held 0 for 5 ticks in phase2 -> command completes 5 ticks late; without macro -> no delay.
